// File: rtl/cp0_unit.sv
// Coprocessor 0 for the pipelined MIPS core: SR/Cause/EPC/PRId plus the
// commit-stage exception/interrupt decision that redirects fetch.
module cp0_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h2022_0707,
  parameter logic [31:0] SR_WMASK   = 32'h0000_FC03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] vpc,
  input  logic        bd,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        eret,
  output logic        req,
  output logic [31:0] epc_out
);

  localparam logic [4:0]  ADDR_SR    = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE = 5'd13;
  localparam logic [4:0]  ADDR_EPC   = 5'd14;
  localparam logic [4:0]  ADDR_PRID  = 5'd15;
  localparam logic [31:0] EXL_BIT    = 32'h0000_0002;

  logic [31:0] sr_r;
  logic        cause_bd_r;
  logic [5:0]  cause_ip_r;
  logic [4:0]  cause_exc_r;
  logic [31:0] epc_r;

  logic        exl_s;
  logic        ie_s;
  logic [5:0]  im_s;
  logic        int_req_s;
  logic        exc_req_s;
  logic        req_s;
  logic        epc_wr_s;
  logic [31:0] sr_next_s;
  logic [31:0] epc_next_s;

  assign exl_s = sr_r[1];
  assign ie_s  = sr_r[0];
  assign im_s  = sr_r[15:10];

  // Exception decision; EXL masks everything so a nested fault keeps EPC.
  always_comb begin
    int_req_s = ie_s & ~exl_s & (|(hw_int & im_s));
    exc_req_s = ~exl_s & (exc_code_in != 5'd0);
    req_s     = ~rst & (int_req_s | exc_req_s);
    epc_wr_s  = we & (addr == ADDR_EPC) & ~req_s;
  end

  assign req     = req_s;
  assign epc_out = epc_wr_s ? wdata : epc_r;

  // Next SR/EPC: a taken exception wins over mtc0; mtc0 SR lands before eret clears EXL.
  always_comb begin
    sr_next_s  = sr_r;
    epc_next_s = epc_r;
    if (req_s) begin
      sr_next_s  = (sr_r | EXL_BIT) & SR_WMASK;
      epc_next_s = bd ? (vpc - 32'd4) : vpc;
    end else begin
      if (we && (addr == ADDR_SR)) begin
        sr_next_s = wdata & SR_WMASK;
      end else begin
        sr_next_s = sr_r;
      end
      if (eret) begin
        sr_next_s = sr_next_s & ~EXL_BIT;
      end else begin
        sr_next_s = sr_next_s;
      end
      if (epc_wr_s) begin
        epc_next_s = wdata;
      end else begin
        epc_next_s = epc_r;
      end
    end
  end

  // Architectural register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_r        <= 32'h0000_0000;
      cause_bd_r  <= 1'b0;
      cause_ip_r  <= 6'd0;
      cause_exc_r <= 5'd0;
      epc_r       <= 32'h0000_0000;
    end else begin
      cause_ip_r <= hw_int;
      sr_r       <= sr_next_s;
      epc_r      <= epc_next_s;
      if (req_s) begin
        cause_bd_r  <= bd;
        cause_exc_r <= int_req_s ? 5'd0 : exc_code_in;
      end
    end
  end

  // mfc0 read mux; shows state from before the current edge.
  always_comb begin
    rdata = 32'h0000_0000;
    case (addr)
      ADDR_SR:    rdata = sr_r;
      ADDR_CAUSE: rdata = {cause_bd_r, 15'd0, cause_ip_r, 3'd0, cause_exc_r, 2'd0};
      ADDR_EPC:   rdata = epc_r;
      ADDR_PRID:  rdata = PRID_VALUE;
      default:    rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed table-driven bench for cp0_unit with hand-computed expectations.
module tb_cp0_unit;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] vpc;
  logic        bd;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        eret;
  logic        req;
  logic [31:0] epc_out;

  int checks;
  int errors;

  cp0_unit dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
    .vpc(vpc), .bd(bd), .exc_code_in(exc_code_in), .hw_int(hw_int),
    .eret(eret), .req(req), .epc_out(epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic        eret;
    logic        exp_req;
    logic [31:0] exp_rdata;
    logic [31:0] exp_epc;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs[NV];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    we = v.we; addr = v.addr; wdata = v.wdata; vpc = v.vpc; bd = v.bd;
    exc_code_in = v.exc; hw_int = v.hw; eret = v.eret;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //              we    addr   wdata          vpc            bd    exc    hw      eret  req   rdata          epc_out
    vecs[0]  = '{1'b0, 5'd12, 32'h0,         32'h0,         1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{1'b0, 5'd13, 32'h0,         32'h0,         1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[2]  = '{1'b0, 5'd14, 32'h0,         32'h0,         1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[3]  = '{1'b0, 5'd15, 32'h0,         32'h0,         1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h2022_0707, 32'h0000_0000};
    vecs[4]  = '{1'b1, 5'd12, 32'hFFFF_FFFF, 32'h0,         1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[5]  = '{1'b0, 5'd12, 32'h0,         32'h0,         1'b0, 5'd5,  6'h3F, 1'b0, 1'b0, 32'h0000_FC03, 32'h0000_0000};
    vecs[6]  = '{1'b0, 5'd13, 32'h0,         32'h0,         1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0000_FC00, 32'h0000_0000};
    vecs[7]  = '{1'b1, 5'd12, 32'h0000_0401, 32'h0,         1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0000_FC03, 32'h0000_0000};
    vecs[8]  = '{1'b0, 5'd13, 32'h0,         32'h0000_3010, 1'b0, 5'd0,  6'h01, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000};
    vecs[9]  = '{1'b0, 5'd14, 32'h0,         32'h0,         1'b0, 5'd0,  6'h01, 1'b0, 1'b0, 32'h0000_3010, 32'h0000_3010};
    vecs[10] = '{1'b0, 5'd12, 32'h0,         32'h0,         1'b0, 5'd0,  6'h01, 1'b0, 1'b0, 32'h0000_0403, 32'h0000_3010};
    vecs[11] = '{1'b0, 5'd13, 32'h0,         32'h0,         1'b0, 5'd0,  6'h01, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_3010};
    vecs[12] = '{1'b1, 5'd14, 32'h0000_3040, 32'h0,         1'b0, 5'd0,  6'h01, 1'b1, 1'b0, 32'h0000_3010, 32'h0000_3040};
    vecs[13] = '{1'b0, 5'd14, 32'h0,         32'h0000_3020, 1'b0, 5'd0,  6'h01, 1'b0, 1'b1, 32'h0000_3040, 32'h0000_3040};
    vecs[14] = '{1'b0, 5'd14, 32'h0,         32'h0,         1'b0, 5'd0,  6'h00, 1'b1, 1'b0, 32'h0000_3020, 32'h0000_3020};
    vecs[15] = '{1'b0, 5'd13, 32'h0,         32'h0000_3100, 1'b0, 5'd12, 6'h01, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_3020};
    vecs[16] = '{1'b0, 5'd13, 32'h0,         32'h0,         1'b0, 5'd12, 6'h00, 1'b0, 1'b0, 32'h0000_0400, 32'h0000_3100};
    vecs[17] = '{1'b0, 5'd14, 32'h0,         32'h0,         1'b0, 5'd0,  6'h00, 1'b1, 1'b0, 32'h0000_3100, 32'h0000_3100};
    vecs[18] = '{1'b1, 5'd12, 32'h0,         32'h0,         1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0000_0401, 32'h0000_3100};
    vecs[19] = '{1'b1, 5'd14, 32'hDEAD_BEEF, 32'h0000_3002, 1'b1, 5'd4,  6'h00, 1'b0, 1'b1, 32'h0000_3100, 32'h0000_3100};
    vecs[20] = '{1'b0, 5'd13, 32'h0,         32'h0,         1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h8000_0010, 32'h0000_2FFE};
    vecs[21] = '{1'b0, 5'd14, 32'h0,         32'h0,         1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0000_2FFE, 32'h0000_2FFE};
    vecs[22] = '{1'b0, 5'd12, 32'h0,         32'h0,         1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0000_0002, 32'h0000_2FFE};
    vecs[23] = '{1'b0, 5'd12, 32'h0,         32'h0,         1'b0, 5'd0,  6'h00, 1'b1, 1'b0, 32'h0000_0002, 32'h0000_2FFE};
    vecs[24] = '{1'b0, 5'd14, 32'h0,         32'h0000_0002, 1'b1, 5'd10, 6'h00, 1'b0, 1'b1, 32'h0000_2FFE, 32'h0000_2FFE};
    vecs[25] = '{1'b0, 5'd14, 32'h0,         32'h0,         1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    vecs[26] = '{1'b0, 5'd13, 32'h0,         32'h0,         1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h8000_0028, 32'hFFFF_FFFE};
    vecs[27] = '{1'b1, 5'd13, 32'hFFFF_FFFF, 32'h0,         1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h8000_0028, 32'hFFFF_FFFE};
    vecs[28] = '{1'b0, 5'd13, 32'h0,         32'h0,         1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h8000_0028, 32'hFFFF_FFFE};
    vecs[29] = '{1'b0, 5'd7,  32'h0,         32'h0,         1'b0, 5'd0,  6'h00, 1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFE};

    rst = 1'b1; we = 1'b0; addr = 5'd0; wdata = 32'h0; vpc = 32'h0; bd = 1'b0;
    exc_code_in = 5'd0; hw_int = 6'd0; eret = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check32($sformatf("v%0d_req", i), {31'd0, req}, {31'd0, vecs[i].exp_req});
      check32($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check32($sformatf("v%0d_epc_out", i), epc_out, vecs[i].exp_epc);
      @(posedge clk);
      #1;
    end

    // mtc0 SR with eret in the same cycle: write lands, then EXL clears.
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_0003; eret = 1'b1;
    @(negedge clk);
    check32("sr_eret_req", {31'd0, req}, 32'd0);
    @(posedge clk);
    #1;
    we = 1'b0; eret = 1'b0;
    @(negedge clk);
    check32("sr_eret_rdata", rdata, 32'h0000_0001);
    @(posedge clk);
    #1;

    // Reset with a pending exception and EXL clear.
    rst = 1'b1; exc_code_in = 5'd10; hw_int = 6'h3F; vpc = 32'h0000_5000;
    @(negedge clk);
    check32("rst_req", {31'd0, req}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; exc_code_in = 5'd0; hw_int = 6'd0;
    addr = 5'd12;
    #1 check32("rst_sr", rdata, 32'h0);
    addr = 5'd13;
    #1 check32("rst_cause", rdata, 32'h0);
    addr = 5'd14;
    #1 check32("rst_epc", rdata, 32'h0);
    check32("rst_epc_out", epc_out, 32'h0);
    check32("post_rst_req", {31'd0, req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
